// File: rtl/set_bit_sequencer_pkg.sv
// Shared types and helpers for the set-bit sequencer.
package set_bit_sequencer_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StEmit
    } state_e;

    // Index width for a vector of w bits; a 1-bit vector still needs a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/lsb_index_enc.sv
// Combinational lowest-set-bit priority encoder with a found flag.
module lsb_index_enc
    import set_bit_sequencer_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned IDX_W = idx_width(W)
) (
    input  logic [W-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    always_comb begin
        idx   = '0;
        found = |vec;
        // Scan high to low so the lowest set bit is the last to write idx.
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/set_bit_sequencer.sv
// Captures a request vector and emits the index of each set bit, lowest first.
module set_bit_sequencer
    import set_bit_sequencer_pkg::*;
#(
    parameter  int unsigned W     = 32,
    localparam int unsigned IDX_W = idx_width(W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [W-1:0]     in_x,
    input  logic             in_inv,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_empty,
    output logic             out_single,
    output logic             out_last,
    output logic             busy
);

    state_e         state_q, state_d;
    logic [W-1:0]   vec_q, vec_d;
    logic           zero_q, zero_d;
    logic           single_q, single_d;

    logic [W-1:0]   cap_vec;
    logic           cap_zero;
    logic           cap_single;
    logic [W-1:0]   vec_cleared;
    logic           emit;
    logic           accept;
    logic           beat;
    logic [IDX_W-1:0] enc_idx;
    logic           enc_found;

    lsb_index_enc #(
        .W     (W),
        .IDX_W (IDX_W)
    ) u_lsb_index_enc (
        .vec   (vec_q),
        .idx   (enc_idx),
        .found (enc_found)
    );

    assign cap_vec     = in_x ^ {W{in_inv}};
    assign cap_zero    = ~|cap_vec;
    assign cap_single  = ~cap_zero & ~|(cap_vec & (cap_vec - W'(1)));
    assign vec_cleared = vec_q & (vec_q - W'(1));

    assign emit       = (state_q == StEmit);
    assign out_vld    = emit;
    assign out_idx    = (emit && enc_found) ? enc_idx : '0;
    assign out_empty  = emit & zero_q;
    assign out_single = emit & single_q;
    // An empty vector also reads as last, since clearing its lowest bit leaves zero.
    assign out_last   = emit & ~|vec_cleared;
    assign busy       = emit;

    assign beat   = out_vld & out_rdy;
    assign in_rdy = ~emit | (beat & out_last);
    assign accept = in_vld & in_rdy;

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        zero_d   = zero_q;
        single_d = single_q;
        if (accept) begin
            state_d  = StEmit;
            vec_d    = cap_vec;
            zero_d   = cap_zero;
            single_d = cap_single;
        end else if (beat) begin
            vec_d = vec_cleared;
            if (out_last) begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            vec_q    <= '0;
            zero_q   <= 1'b0;
            single_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            zero_q   <= zero_d;
            single_q <= single_d;
        end
    end

endmodule

// File: tb/tb_set_bit_sequencer.sv
// Directed self-checking bench for set_bit_sequencer at W=8.
module tb_set_bit_sequencer;

    localparam int unsigned W     = 8;
    localparam int unsigned IDX_W = 3;

    logic             clk;
    logic             rst_n;
    logic             in_vld;
    logic             in_rdy;
    logic [W-1:0]     in_x;
    logic             in_inv;
    logic             out_vld;
    logic             out_rdy;
    logic [IDX_W-1:0] out_idx;
    logic             out_empty;
    logic             out_single;
    logic             out_last;
    logic             busy;

    int total = 0;
    int bad   = 0;

    set_bit_sequencer #(
        .W (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .in_x       (in_x),
        .in_inv     (in_inv),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .out_idx    (out_idx),
        .out_empty  (out_empty),
        .out_single (out_single),
        .out_last   (out_last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present one vector while idle and advance to the cycle its first beat shows.
    task automatic send(input logic [W-1:0] x, input logic inv);
        check("send_in_rdy", 32'(in_rdy), 32'd1);
        in_x   = x;
        in_inv = inv;
        in_vld = 1'b1;
        @(posedge clk);
        #1;
        in_vld = 1'b0;
    endtask

    // Check the presented beat, then let it be consumed (out_rdy assumed high).
    task automatic expect_beat(input string tag, input int idx, input logic empty,
                               input logic single, input logic last);
        check({tag, "_vld"}, 32'(out_vld), 32'd1);
        check({tag, "_idx"}, 32'(out_idx), 32'(idx));
        check({tag, "_empty"}, 32'(out_empty), 32'(empty));
        check({tag, "_single"}, 32'(out_single), 32'(single));
        check({tag, "_last"}, 32'(out_last), 32'(last));
        @(posedge clk);
        #1;
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_idle_vld"}, 32'(out_vld), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_rdy"}, 32'(in_rdy), 32'd1);
    endtask

    initial begin
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        in_x    = '0;
        in_inv  = 1'b0;
        out_rdy = 1'b1;
        #1;
        check("rst_vld", 32'(out_vld), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_idx", 32'(out_idx), 32'd0);
        check("rst_empty", 32'(out_empty), 32'd0);
        check("rst_single", 32'(out_single), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_rdy", 32'(in_rdy), 32'd1);

        // Zero vector: one empty beat.
        send(8'h00, 1'b0);
        expect_beat("zero", 0, 1'b1, 1'b0, 1'b1);
        expect_idle("zero");

        // One-hot.
        send(8'h10, 1'b0);
        expect_beat("onehot", 4, 1'b0, 1'b1, 1'b1);
        expect_idle("onehot");

        // Multi-set 0xA5 -> 0,2,5,7.
        send(8'hA5, 1'b0);
        expect_beat("a5_b0", 0, 1'b0, 1'b0, 1'b0);
        expect_beat("a5_b1", 2, 1'b0, 1'b0, 1'b0);
        expect_beat("a5_b2", 5, 1'b0, 1'b0, 1'b0);
        expect_beat("a5_b3", 7, 1'b0, 1'b0, 1'b1);
        expect_idle("a5");

        // Inverted capture 0xFE -> 0x01, with 0x06 accepted on the last-beat handshake.
        send(8'hFE, 1'b1);
        check("inv_vld", 32'(out_vld), 32'd1);
        check("inv_idx", 32'(out_idx), 32'd0);
        check("inv_single", 32'(out_single), 32'd1);
        check("inv_last", 32'(out_last), 32'd1);
        in_x   = 8'h06;
        in_inv = 1'b0;
        in_vld = 1'b1;
        #1;
        check("b2b_in_rdy", 32'(in_rdy), 32'd1);
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        expect_beat("b2b_b0", 1, 1'b0, 1'b0, 1'b0);
        expect_beat("b2b_b1", 2, 1'b0, 1'b0, 1'b1);
        expect_idle("b2b");

        // Backpressure holds the beat stable.
        send(8'h06, 1'b0);
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_vld", 32'(out_vld), 32'd1);
            check("bp_idx", 32'(out_idx), 32'd1);
            check("bp_last", 32'(out_last), 32'd0);
            check("bp_in_rdy", 32'(in_rdy), 32'd0);
            @(posedge clk);
            #1;
        end
        out_rdy = 1'b1;
        expect_beat("bp_b0", 1, 1'b0, 1'b0, 1'b0);
        expect_beat("bp_b1", 2, 1'b0, 1'b0, 1'b1);
        expect_idle("bp");

        // Reset mid-sequence abandons 0xFF.
        send(8'hFF, 1'b0);
        expect_beat("ff_b0", 0, 1'b0, 1'b0, 1'b0);
        expect_beat("ff_b1", 1, 1'b0, 1'b0, 1'b0);
        expect_beat("ff_b2", 2, 1'b0, 1'b0, 1'b0);
        check("ff_pre_rst_idx", 32'(out_idx), 32'd3);
        rst_n = 1'b0;
        #1;
        check("midrst_vld", 32'(out_vld), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        #2;
        rst_n = 1'b1;
        #1;
        check("midrst_in_rdy", 32'(in_rdy), 32'd1);
        send(8'h80, 1'b0);
        expect_beat("post_rst", 7, 1'b0, 1'b1, 1'b1);
        expect_idle("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/set_bit_sequencer.md
Name: set_bit_sequencer

Overview:
- Scheduler that accepts a W-bit request vector over a valid/ready handshake and applies optional inversion.
- Classifies the vector as zero, one-hot or multi-set, then emits the index of every set bit, lowest first, one beat per cycle on a valid/ready output stream.
- Sits between a requester and any consumer that services one bit position at a time (e.g. a per-bit resource issue).

Parameters:
- W, 32, request vector width (W >= 1).
- IDX_W, (W > 1) ? $clog2(W) : 1, width of the emitted index. Derived; not for override.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous reset, active-low.
- in_vld  input  1  request vector valid.
- in_rdy  output  1  block can accept a vector.
- in_x  input  W  request vector.
- in_inv  input  1  when 1, the vector is bitwise inverted at capture (sequence the clear bits).
- out_vld  output  1  beat valid.
- out_rdy  input  1  consumer accepts the beat.
- out_idx  output  IDX_W  bit index of the current beat.
- out_empty  output  1  captured vector had no set bits.
- out_single  output  1  captured vector had exactly one set bit.
- out_last  output  1  final beat for this vector.
- busy  output  1  state != IDLE.

Behaviour:
- States: IDLE, EMIT. Reset is async on rst_n low: state=IDLE, held vector=0, out_vld=0, out_idx=0, out_empty=0, out_single=0, out_last=0, busy=0. in_rdy=1 once out of reset.
- in_rdy = (state==IDLE) | (out_vld & out_rdy & out_last). This allows back-to-back vectors with no bubble.
- Capture on in_vld & in_rdy:
  - vec <= in_x ^ {W{in_inv}}.
  - Latch classification: zero = ~|vec; single = nonzero & ~|(vec & (vec-1)).
  - Go to EMIT. out_vld rises the next cycle (latency 1).
  - in_inv is sampled at capture only.
- In EMIT, outputs are combinational from registered vec and flags:
  - out_idx = index of the lowest set bit of vec (0 when vec==0).
  - out_empty = zero flag; out_single = single flag.
  - out_last = (vec & (vec-1)) == 0. This covers both the zero case and the final remaining bit.
- Zero vector: exactly one beat, out_empty=1, out_last=1, out_idx=0.
- One-hot: exactly one beat, out_single=1, out_last=1.
- Multi-set: popcount beats, out_empty=0, out_single=0. out_last is asserted only on the highest set bit.
- Beat handshake on out_vld & out_rdy: vec <= vec & (vec-1), clearing the lowest bit.
  - If out_last: go to IDLE, unless a new vector is captured the same cycle, in which case stay in EMIT with the new vec.
- Backpressure: while out_vld & ~out_rdy, every out_* signal and vec hold stable. out_vld never drops without a handshake.
- Throughput: one beat per cycle with out_rdy held high. A new vector's first beat follows the previous last beat on the very next cycle.
- W==1: multi-set is impossible. The one bit gives either an empty beat or a single beat with idx 0.
- Reset mid-EMIT: the sequence is abandoned. out_vld drops asynchronously and no partial vector is retained.
- in_vld while not in_rdy is ignored; the requester must hold in_vld/in_x until in_rdy.

Decomposition:
- Package set_bit_sequencer_pkg holds the state enum (IDLE, EMIT) and the IDX_W derivation function.
- One sub-module, lsb_index_enc: parameter W, combinational lowest-set-bit priority encoder. It outputs the index plus a found flag, and is reusable elsewhere.
- Classification and bit-clear arithmetic stay inline.

Test Plan:
- W=8, in_x=8'h00, in_inv=0, out_rdy=1 -> one beat: out_empty=1, out_last=1, out_idx=0. in_rdy=1 on the following cycle.
- in_x=8'h10, in_inv=0 -> one beat: out_idx=4, out_single=1, out_last=1.
- in_x=8'hA5, out_rdy=1 -> 4 consecutive beats with out_idx 0,2,5,7. out_last only on idx 7; out_single=0 and out_empty=0 on all beats.
- in_x=8'hFE, in_inv=1 (captured 8'h01) -> one beat: out_idx=0, out_single=1. A second vector 8'h06 presented alongside is accepted on that last-beat handshake, and its idx 1 appears the next cycle with no bubble.
- in_x=8'h06 with out_rdy=0 for 3 cycles -> out_vld=1 and out_idx=1 held stable for 3 cycles. Then beats idx 1 then idx 2 (last).
- in_x=8'hFF, assert rst_n=0 after 3 beats -> out_vld=0 and busy=0 immediately. After release, in_rdy=1. A new vector 8'h80 yields a single beat with idx 7 and no residue from 8'hFF.
